// File: rtl/alsu_pipe.sv
// alsu_pipe: two-stage arithmetic/logic/shift unit. Inputs are registered first,
// and the result is registered one edge later.
module alsu_pipe #(
    parameter int WIDTH          = 8,
    parameter     INPUT_PRIORITY = "A",
    parameter     FULL_ADDER     = "ON"
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               cin,
    input  logic               serial_in,
    input  logic               red_op_A,
    input  logic               red_op_B,
    input  logic               bypass_A,
    input  logic               bypass_B,
    input  logic               direction,
    input  logic [2:0]         opcode,
    output logic [2*WIDTH-1:0] out,
    output logic               out_valid,
    output logic [15:0]        leds,
    output logic [7:0]         err_cnt
);
    localparam int OW    = 2 * WIDTH;
    localparam bit PRI_A = (INPUT_PRIORITY == "A");
    localparam bit FA    = (FULL_ADDER == "ON");

    logic [WIDTH-1:0] a_r, b_r;
    logic [2:0]       op_r;
    logic             valid_r, cin_r, ser_r, red_a_r, red_b_r, byp_a_r, byp_b_r, dir_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {valid_r, cin_r, ser_r, red_a_r, red_b_r, byp_a_r, byp_b_r, dir_r} <= '0;
            a_r  <= '0;
            b_r  <= '0;
            op_r <= '0;
        end else begin
            {valid_r, cin_r, ser_r, red_a_r, red_b_r, byp_a_r, byp_b_r, dir_r} <=
                {in_valid, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction};
            a_r  <= A;
            b_r  <= B;
            op_r <= opcode;
        end
    end

    logic          sel_byp_a, sel_byp_b, sel_red_a, sel_red_b, invalid;
    logic [OW-1:0] a_x, b_x, res, nxt;

    // A wins a tie only when INPUT_PRIORITY is "A"; the B select is whatever A leaves.
    assign sel_byp_a = byp_a_r & (~byp_b_r | PRI_A);
    assign sel_byp_b = byp_b_r & ~sel_byp_a;
    assign sel_red_a = red_a_r & (~red_b_r | PRI_A);
    assign sel_red_b = red_b_r & ~sel_red_a;
    assign a_x       = OW'(a_r);
    assign b_x       = OW'(b_r);
    assign invalid   = ~(byp_a_r | byp_b_r) & ((op_r > 3'd5) | ((red_a_r | red_b_r) & (op_r > 3'd1)));

    always_comb begin
        res = '0;
        case (op_r)
            3'd0:    res = sel_red_a ? OW'(&a_r) : sel_red_b ? OW'(&b_r) : a_x & b_x;
            3'd1:    res = sel_red_a ? OW'(^a_r) : sel_red_b ? OW'(^b_r) : a_x ^ b_x;
            3'd2:    res = a_x + b_x + OW'(cin_r & FA);
            3'd3:    res = a_x * b_x;
            3'd4:    res = dir_r ? {out[OW-2:0], ser_r} : {ser_r, out[OW-1:1]};
            3'd5:    res = dir_r ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
            default: res = '0;
        endcase
    end

    assign nxt = sel_byp_a ? a_x : sel_byp_b ? b_x : invalid ? '0 : res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            leds      <= '0;
            err_cnt   <= '0;
        end else begin
            out_valid <= valid_r;
            if (valid_r) begin
                out     <= nxt;
                leds    <= invalid ? ~leds : '0;
                err_cnt <= err_cnt + 8'(invalid && err_cnt != 8'hFF);
            end
        end
    end
endmodule
